// File: rtl/exerion_loader_pkg.sv
// Shared types and image layout for the Exerion ROM loader: region table,
// loader states and the running-checksum helper.
package exerion_loader_pkg;

   localparam int PKG_NREG = 7;
   localparam int PKG_AW   = 25;
   localparam int PKG_LW   = 16;

   typedef enum logic [2:0] {
      REG_MAIN  = 3'd0,
      REG_SUB   = 3'd1,
      REG_CHAR  = 3'd2,
      REG_SPR   = 3'd3,
      REG_BG    = 3'd4,
      REG_CPROM = 3'd5,
      REG_LPROM = 3'd6
   } region_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_e;

   // Regions are packed back to back: each base is the previous base plus its size.
   localparam logic [PKG_AW-1:0] REG_SIZE [PKG_NREG] = '{
      25'd512, 25'd256, 25'd256, 25'd256, 25'd512, 25'd32, 25'd352
   };
   localparam logic [PKG_AW-1:0] REG_BASE [PKG_NREG] = '{
      25'd0, 25'd512, 25'd768, 25'd1024, 25'd1280, 25'd1792, 25'd1824
   };
   localparam logic [PKG_AW-1:0] IMG_SIZE = 25'd2176;

   function automatic logic [15:0] cksum_add(input logic [15:0] sum, input logic [7:0] data);
      return sum + {8'h00, data};
   endfunction

endpackage

// File: rtl/exerion_region_decode.sv
// Combinational decode of a download byte address into a one-hot region hit,
// the region-local offset and an out-of-image flag.
module exerion_region_decode
   import exerion_loader_pkg::*;
(
   input  logic [PKG_AW-1:0]   addr,
   output logic [PKG_NREG-1:0] hit,
   output logic [PKG_LW-1:0]   offset,
   output logic                out_of_range
);

   // Compare the address against every region window.
   always_comb begin
      hit          = '0;
      offset       = '0;
      out_of_range = (addr >= IMG_SIZE);
      for (int i = 0; i < PKG_NREG; i++) begin
         if ((addr >= REG_BASE[i]) && (addr < (REG_BASE[i] + REG_SIZE[i]))) begin
            hit[i] = 1'b1;
            offset = PKG_LW'(addr - REG_BASE[i]);
         end else begin
            hit[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/exerion_rom_loader.sv
// Turns the HPS ioctl download stream into per-region ROM write pulses and
// holds the core in reset until a complete image is in. Optional image
// checksum verification is enabled with EXERION_LOADER_CKSUM_EN.
module exerion_rom_loader
   import exerion_loader_pkg::*;
#(
   parameter int NREG = 7,
   parameter int AW   = 25,
   parameter int LW   = 16
`ifdef EXERION_LOADER_CKSUM_EN
   ,
   parameter logic [15:0] EXP_CKSUM = 16'h0000
`endif
)
(
   input  logic            clk_sys,
   input  logic            RESET_n,
   input  logic            dn_download,
   input  logic [7:0]      dn_index,
   input  logic [AW-1:0]   dn_addr,
   input  logic [7:0]      dn_data,
   input  logic            dn_wr,
   output logic [NREG-1:0] rom_we,
   output logic [LW-1:0]   rom_addr,
   output logic [7:0]      rom_data,
   output logic            rom_ready,
   output logic            load_err,
   output logic            core_reset_n
`ifdef EXERION_LOADER_CKSUM_EN
   ,
   output logic [15:0]     rom_cksum
`endif
);

   state_e          state_r, state_s;
   logic [AW-1:0]   cnt_r, cnt_s;
   logic            err_r, err_s;
   logic            ready_r, ready_s;
   logic [NREG-1:0] we_r;
   logic [LW-1:0]   addr_r;
   logic [7:0]      data_r;
   logic            core_rst_r;
   logic [NREG-1:0] hit_s;
   logic [LW-1:0]   off_s;
   logic            oor_s;
   logic            accept_s;
   logic            start_s;
   logic            cksum_bad_s;
`ifdef EXERION_LOADER_CKSUM_EN
   logic [15:0]     sum_r, sum_s;
`endif

   exerion_region_decode u_decode (
      .addr         (dn_addr),
      .hit          (hit_s),
      .offset       (off_s),
      .out_of_range (oor_s)
   );

   assign accept_s = (state_r == LOAD) && dn_wr && (dn_index == 8'd0);
   assign start_s  = dn_download && (dn_index == 8'd0);

   // Next-state, byte counter, error and ready computation.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      err_s       = err_r;
      ready_s     = ready_r;
      cksum_bad_s = 1'b0;
`ifdef EXERION_LOADER_CKSUM_EN
      sum_s       = sum_r;
`endif
      case (state_r)
         IDLE, DONE, ERR: begin
            if (start_s) begin
               state_s = LOAD;
               cnt_s   = '0;
               err_s   = 1'b0;
               ready_s = 1'b0;
`ifdef EXERION_LOADER_CKSUM_EN
               sum_s   = 16'h0000;
`endif
            end else begin
               state_s = state_r;
            end
         end
         LOAD: begin
            // The final write may coincide with the falling edge, so count it before the exit check.
            if (accept_s) begin
               cnt_s = (cnt_r == {AW{1'b1}}) ? cnt_r : (cnt_r + 1'b1);
               err_s = err_r | oor_s;
`ifdef EXERION_LOADER_CKSUM_EN
               sum_s = oor_s ? sum_r : cksum_add(sum_r, dn_data);
`endif
            end else begin
               cnt_s = cnt_r;
            end
`ifdef EXERION_LOADER_CKSUM_EN
            cksum_bad_s = (EXP_CKSUM != 16'h0000) && (sum_s != EXP_CKSUM);
`endif
            if (!dn_download) begin
               if ((cnt_s >= IMG_SIZE) && !err_s && !cksum_bad_s) begin
                  state_s = DONE;
                  ready_s = 1'b1;
               end else begin
                  state_s = ERR;
                  err_s   = 1'b1;
                  ready_s = 1'b0;
               end
            end else begin
               state_s = LOAD;
            end
         end
         default: begin
            state_s = IDLE;
            ready_s = 1'b0;
         end
      endcase
   end

   // Loader state and bookkeeping registers.
   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         err_r   <= 1'b0;
         ready_r <= 1'b0;
`ifdef EXERION_LOADER_CKSUM_EN
         sum_r   <= 16'h0000;
`endif
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         err_r   <= err_s;
         ready_r <= ready_s;
`ifdef EXERION_LOADER_CKSUM_EN
         sum_r   <= sum_s;
`endif
      end
   end

   // Registered write pulse towards the ROM arrays and the core reset.
   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         we_r       <= '0;
         addr_r     <= '0;
         data_r     <= 8'h00;
         core_rst_r <= 1'b0;
      end else begin
         we_r       <= (accept_s && !oor_s) ? hit_s : '0;
         addr_r     <= accept_s ? off_s : addr_r;
         data_r     <= dn_data;
         core_rst_r <= RESET_n & ready_r;
      end
   end

   assign rom_we       = we_r;
   assign rom_addr     = addr_r;
   assign rom_data     = data_r;
   assign rom_ready    = ready_r;
   assign load_err     = err_r;
   assign core_reset_n = core_rst_r;
`ifdef EXERION_LOADER_CKSUM_EN
   assign rom_cksum    = sum_r;
`endif

endmodule
